// File: rtl/irrigation_ctrl_seq.sv
// Multi-zone irrigation controller: synchronised, debounced tank/climate sensors drive per-zone
// drip/spray valve FSMs sharing one sprinkler grant, plus a two-page 7-segment status display.
module irrigation_ctrl_seq #(
    parameter int ZONES         = 2,
    parameter int DEB_CYCLES    = 4,
    parameter int MIN_ON_CYCLES = 8,
    parameter int DISP_CYCLES   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     lvl_h,
    input  logic                     lvl_m,
    input  logic                     lvl_l,
    input  logic [ZONES-1:0]         soil_wet,
    input  logic                     air_wet,
    input  logic                     temp_hi,
    input  logic                     disp_auto,
    input  logic                     disp_sel,
    input  logic [$clog2(ZONES)-1:0] disp_zone,
    output logic                     err,
    output logic                     alarm,
    output logic [ZONES-1:0]         drip,
    output logic [ZONES-1:0]         spray,
    output logic [6:0]               seg,
    output logic                     dp
);

    localparam int          NS         = ZONES + 5;
    localparam int          ZW         = $clog2(ZONES);
    localparam logic [7:0]  DEB_LAST   = 8'(DEB_CYCLES - 1);
    localparam logic [15:0] MIN_W      = 16'(MIN_ON_CYCLES);
    localparam logic [15:0] DWELL_LAST = 16'(MIN_ON_CYCLES - 1);
    localparam logic [15:0] DISP_LAST  = 16'(DISP_CYCLES - 1);

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_E    = 7'b1111001;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_D    = 7'b1011110;
    localparam logic [6:0] SEG_S    = 7'b1101101;

    typedef enum logic [1:0] {
        Z_OFF   = 2'd0,
        Z_DRIP  = 2'd1,
        Z_SPRAY = 2'd2
    } zst_t;

    // Bit map: 0 H, 1 M, 2 L, 3.. soil, then air, then temp.
    logic [NS-1:0] raw;
    logic [NS-1:0] sync1_q, sync2_q, filt_q, filt_d;
    logic [7:0]    deb_cnt_q [NS];
    logic [7:0]    deb_cnt_d [NS];

    assign raw = {temp_hi, air_wet, soil_wet, lvl_l, lvl_m, lvl_h};

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < NS; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            for (int i = 0; i < NS; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            for (int i = 0; i < NS; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

    logic             f_h, f_m, f_l, f_air, f_hot;
    logic [ZONES-1:0] f_wet;
    logic             err_d, alarm_d;
    logic [ZONES-1:0] drip_req, spray_req;

    assign f_h      = filt_q[0];
    assign f_m      = filt_q[1];
    assign f_l      = filt_q[2];
    assign f_wet    = filt_q[3 +: ZONES];
    assign f_air    = filt_q[ZONES+3];
    assign f_hot    = filt_q[ZONES+4];
    assign err_d    = (f_h & ~f_m) | (f_m & ~f_l);
    assign alarm_d  = err_d | ~f_l;
    assign drip_req  = ~f_wet & {ZONES{~f_air | (~f_hot & f_m)}};
    assign spray_req = ~f_wet & {ZONES{f_air & (f_hot | ~f_m)}};

    zst_t             st_q [ZONES];
    zst_t             st_d [ZONES];
    logic [15:0]      dwell_q [ZONES];
    logic [15:0]      dwell_d [ZONES];
    logic             err_q, alarm_q, dp_q, dp_d, disp_auto_q;
    logic [ZONES-1:0] drip_q, spray_q, drip_d, spray_d;
    logic [6:0]       seg_q, seg_d;
    logic [15:0]      tmr_q, tmr_d;
    logic             grant_taken;

    // Entry is gated by the alarm being registered on this edge, so no valve opens alongside
    // a visible alarm; an already-open valve is cut on the edge after alarm becomes visible.
    always_comb begin
        grant_taken = 1'b0;
        for (int z = 0; z < ZONES; z++) begin
            if (st_q[z] == Z_SPRAY) grant_taken = 1'b1;
        end
        for (int z = 0; z < ZONES; z++) begin
            st_d[z]    = st_q[z];
            dwell_d[z] = (dwell_q[z] == MIN_W) ? dwell_q[z] : dwell_q[z] + 16'd1;
            case (st_q[z])
                Z_DRIP: begin
                    if (alarm_q || (dwell_q[z] >= DWELL_LAST && !drip_req[z])) st_d[z] = Z_OFF;
                end
                Z_SPRAY: begin
                    if (alarm_q || (dwell_q[z] >= DWELL_LAST && !spray_req[z])) st_d[z] = Z_OFF;
                end
                default: begin
                    dwell_d[z] = '0;
                    if (!alarm_d) begin
                        if (drip_req[z]) begin
                            st_d[z] = Z_DRIP;
                        end else if (spray_req[z] && !grant_taken) begin
                            st_d[z]     = Z_SPRAY;
                            grant_taken = 1'b1;
                        end
                    end
                end
            endcase
            drip_d[z]  = (st_d[z] == Z_DRIP);
            spray_d[z] = (st_d[z] == Z_SPRAY);
        end
    end

    logic [1:0]    lvl_cnt;
    logic [ZW-1:0] zsel;
    logic [6:0]    tank_seg, zone_seg;

    assign lvl_cnt = {1'b0, f_h} + {1'b0, f_m} + {1'b0, f_l};
    assign zsel    = (int'(disp_zone) < ZONES) ? disp_zone : '0;

    always_comb begin
        tank_seg = SEG_0;
        if (err_d) begin
            tank_seg = SEG_E;
        end else begin
            case (lvl_cnt)
                2'd1:    tank_seg = SEG_1;
                2'd2:    tank_seg = SEG_2;
                2'd3:    tank_seg = SEG_3;
                default: tank_seg = SEG_0;
            endcase
        end
        case (st_d[zsel])
            Z_DRIP:  zone_seg = SEG_D;
            Z_SPRAY: zone_seg = SEG_S;
            default: zone_seg = SEG_DASH;
        endcase
    end

    // A fresh 0->1 on disp_auto restarts the page cycle on the tank page.
    always_comb begin
        tmr_d = tmr_q;
        dp_d  = dp_q;
        if (!disp_auto) begin
            tmr_d = '0;
            dp_d  = disp_sel;
        end else if (!disp_auto_q) begin
            tmr_d = '0;
            dp_d  = 1'b0;
        end else if (tmr_q == DISP_LAST) begin
            tmr_d = '0;
            dp_d  = ~dp_q;
        end else begin
            tmr_d = tmr_q + 16'd1;
        end
        seg_d = dp_d ? zone_seg : tank_seg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int z = 0; z < ZONES; z++) begin
                st_q[z]    <= Z_OFF;
                dwell_q[z] <= '0;
            end
            err_q       <= 1'b0;
            alarm_q     <= 1'b1;
            drip_q      <= '0;
            spray_q     <= '0;
            seg_q       <= SEG_0;
            dp_q        <= 1'b0;
            tmr_q       <= '0;
            disp_auto_q <= 1'b0;
        end else begin
            for (int z = 0; z < ZONES; z++) begin
                st_q[z]    <= st_d[z];
                dwell_q[z] <= dwell_d[z];
            end
            err_q       <= err_d;
            alarm_q     <= alarm_d;
            drip_q      <= drip_d;
            spray_q     <= spray_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            tmr_q       <= tmr_d;
            disp_auto_q <= disp_auto;
        end
    end

    assign err   = err_q;
    assign alarm = alarm_q;
    assign drip  = drip_q;
    assign spray = spray_q;
    assign seg   = seg_q;
    assign dp    = dp_q;

endmodule
